// File: rtl/tl_ul_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_sram_responder
// Purpose  : TileLink-UL manager endpoint. Consumes single-beat A-channel
//            requests, performs them against a local word-addressed SRAM and
//            returns one D-channel acknowledgement per request through a
//            single-entry response buffer (1 beat/cycle sustained).
// Ports    : clock, reset_n (synchronous, active-low)
//            A channel in : a_valid, a_opcode, a_param, a_size, a_source,
//                           a_address, a_mask, a_data ; out: a_ready
//            D channel out: d_valid, d_opcode, d_param, d_size, d_source,
//                           d_sink, d_denied, d_data, d_corrupt ; in: d_ready
// Options  : TL_SRAM_RESP_STALL_EN - adds an 8-bit LFSR that pseudo-randomly
//            deasserts a_ready (A-channel backpressure only).
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_sram_responder #(
  parameter int                ADDR_W     = 26,
  parameter int                SRC_W      = 7,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE       = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_sink,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LSB_HI = DEPTH_LOG2 + 2;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state, state_next;
  logic                  a_fire;
  logic                  stall;
  logic [3:0]            lanes;
  logic                  aligned;
  logic                  in_range;
  logic                  denied;
  logic                  is_put;
  logic [2:0]            rsp_op;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem [DEPTH];
  logic                  unused_ok;

  assign unused_ok = ^a_param;

`ifdef TL_SRAM_RESP_STALL_EN
  // Fibonacci LFSR, taps 8,6,5,4; bit 0 high blocks A acceptance.
  logic [7:0] lfsr;
  always_ff @(posedge clock) begin
    if (!reset_n) lfsr <= 8'h01;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Response buffer FSM
  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_ready    = ((state == EMPTY) || d_ready) && !stall;
    a_fire     = a_valid && a_ready;
    if (a_fire)                          state_next = FULL;
    else if (state == FULL && d_ready)   state_next = EMPTY;
  end

  assign d_valid = (state == FULL);
  assign d_param = 2'b00;
  assign d_sink  = 1'b0;

  // Request decode and legality
  always_comb begin
    lanes   = 4'h0;
    aligned = 1'b0;
    is_put  = 1'b0;
    rsp_op  = D_ACK;
    case (a_size)
      3'd0: begin
        lanes   = 4'b0001 << a_address[1:0];
        aligned = 1'b1;
      end
      3'd1: begin
        lanes   = a_address[1] ? 4'b1100 : 4'b0011;
        aligned = !a_address[0];
      end
      3'd2: begin
        lanes   = 4'hf;
        aligned = (a_address[1:0] == 2'b00);
      end
      default: begin
        lanes   = 4'h0;
        aligned = 1'b0;
      end
    endcase
    // BASE is aligned to the region size, so the region match is an
    // equality on the bits above the word index.
    in_range = (a_address[ADDR_W-1:LSB_HI] == BASE[ADDR_W-1:LSB_HI]);
    denied   = (a_size > 3'd2) || !in_range || !aligned;
    case (a_opcode)
      A_PUT_FULL: begin
        is_put = 1'b1;
        if (a_mask != lanes) denied = 1'b1;
      end
      A_PUT_PARTIAL: begin
        is_put = 1'b1;
        if ((a_mask & ~lanes) != 4'h0) denied = 1'b1;
      end
      A_ARITH, A_LOGICAL: begin
        rsp_op = D_ACK_DATA;
        denied = 1'b1;
      end
      A_GET:    rsp_op = D_ACK_DATA;
      A_INTENT: rsp_op = D_HINT_ACK;
      default:  denied = 1'b1;
    endcase
  end

  // Word index within the region; low bits are unaffected by the aligned BASE.
  assign idx   = a_address[LSB_HI-1:2];
  assign wr_en = a_fire && reset_n && is_put && !denied;

  // SRAM array: byte-lane writes, contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  // Response register; only loads on an A fire, so it holds while stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      d_opcode  <= 3'd0;
      d_size    <= 3'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= 32'h0;
    end else if (a_fire) begin
      d_opcode  <= rsp_op;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= denied;
      d_corrupt <= (rsp_op == D_ACK_DATA) && denied;
      d_data    <= (rsp_op == D_ACK_DATA && !denied) ? mem[idx] : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_ul_sram_responder
// Purpose  : Scoreboard bench for tl_ul_sram_responder. Accepted requests are
//            turned into expected responses by a byte-level reference model
//            and queued; a monitor pops and compares on each D handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_ul_sram_responder;

  localparam int          DL      = 10;
  localparam int unsigned REGION  = 4 * (1 << DL);
  localparam int unsigned BASE_A  = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [6:0]  a_source;
  logic [25:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param;
  logic [6:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [31:0] d_data;

  tl_ul_sram_responder #(.ADDR_W(26), .SRC_W(7), .DEPTH_LOG2(DL), .BASE(26'h0)) dut (
    .clock(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic        denied;
    logic        corrupt;
    logic [2:0]  size;
    logic [6:0]  src;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem_m [0:(1<<DL)-1];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  bit          seen_rst = 0;
  bit          rst_prev = 0;
  bit          hold_v = 0;
  logic [49:0] snap;
  logic [7:0]  lfsr_m = 8'h01;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Byte lanes covered by a transfer of 2^size bytes starting at addr.
  function automatic logic [3:0] lanes_of(logic [2:0] size, int unsigned addr);
    logic [3:0] l = 4'h0;
    int unsigned off = addr % 4;
    int unsigned nb;
    if (size <= 2) begin
      nb = 1 << size;
      for (int b = 0; b < 4; b++) l[b] = (b >= off) && (b < off + nb);
    end
    return l;
  endfunction

  // Reference model: computes the response and applies any write.
  function automatic rsp_t model(logic [2:0] op, logic [2:0] size, logic [6:0] src,
                                 int unsigned addr, logic [3:0] mask, logic [31:0] data);
    rsp_t        r = '0;
    bit          den = 0;
    logic [3:0]  ln = lanes_of(size, addr);
    int unsigned word;
    r.size = size;
    r.src  = src;
    if (size > 2) den = 1;
    else if (addr % (1 << size) != 0) den = 1;
    if (addr < BASE_A || addr >= BASE_A + REGION) den = 1;
    case (op)
      3'd0:       begin r.op = 3'd0; if (mask != ln) den = 1; end
      3'd1:       begin r.op = 3'd0; if ((mask & ~ln) != 0) den = 1; end
      3'd2, 3'd3: begin r.op = 3'd1; den = 1; end
      3'd4:       r.op = 3'd1;
      3'd5:       r.op = 3'd2;
      default:    begin r.op = 3'd0; den = 1; end
    endcase
    word      = (addr - BASE_A) / 4;
    r.denied  = den;
    r.corrupt = (r.op == 3'd1) && den;
    r.data    = (r.op == 3'd1 && !den) ? mem_m[word] : 32'h0;
    if (!den && op <= 3'd1)
      for (int b = 0; b < 4; b++) if (mask[b]) mem_m[word][8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic exp_ready();
    logic r = (q.size() == 0) || d_ready;
`ifdef TL_SRAM_RESP_STALL_EN
    r = r && !lfsr_m[0];
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      seen_rst = 1;
      lfsr_m   = 8'h01;
    end else begin
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [49:0] cur;
    rsp_t        e;
    if (seen_rst) begin
      cur = {d_param, d_sink, d_opcode, d_denied, d_corrupt, d_size, d_source, d_data};
      chk("a_ready", 64'(a_ready), 64'(exp_ready()));
      chk("d_valid", 64'(d_valid), 64'(q.size() > 0));
      if (rst_prev) chk("reset_zero", 64'({d_valid, cur}), 64'h0);
      if (d_valid && !d_ready) begin
        if (hold_v) chk("d_hold", 64'(cur), 64'(snap));
        hold_v = 1;
        snap   = cur;
      end else begin
        hold_v = 0;
      end
      if (d_valid && d_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("d_rsp", 64'(cur), 64'({2'b00, 1'b0, e.op, e.denied, e.corrupt, e.size, e.src, e.data}));
      end
      if (!reset_n) begin
        q.delete();
        hold_v = 0;
      end else if (a_valid && a_ready) begin
        q.push_back(model(a_opcode, a_size, a_source, int'(a_address), a_mask, a_data));
      end
      rst_prev = !reset_n;
    end
  end

  initial begin
    d_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       d_ready = 1'b1;
        1:       d_ready = ($urandom_range(0, 9) < 7);
        default: d_ready = 1'b0;
      endcase
    end
  end

  task automatic send(logic [2:0] op, logic [2:0] size, logic [6:0] src,
                      logic [25:0] addr, logic [3:0] mask, logic [31:0] data);
    int n = 0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    @(negedge clk);
    while (!a_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got a_ready 0 expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  initial begin
    logic [25:0] addr;
    logic [2:0]  op, size;
    int          sel;
    reset_n = 1'b0;
    a_valid = 1'b0;
    a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 7'd0;
    a_address = 26'd0; a_mask = 4'd0; a_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Preload the words the bench reads from
    for (int w = 0; w < 16; w++) send(3'd0, 3'd2, 7'd1, 26'(w * 4), 4'hf, $urandom);
    send(3'd0, 3'd2, 7'd1, 26'(REGION - 4), 4'hf, $urandom);

    // Directed: full write, partial write, read-backs
    send(3'd0, 3'd2, 7'h05, 26'h10, 4'hf, 32'hDEADBEEF);
    send(3'd4, 3'd2, 7'h05, 26'h10, 4'h0, 32'h0);
    send(3'd1, 3'd2, 7'h06, 26'h10, 4'b0010, 32'h0000AA00);
    send(3'd4, 3'd2, 7'h06, 26'h10, 4'h0, 32'h0);
    // Out of range and misaligned Gets, then confirm SRAM unchanged
    send(3'd4, 3'd2, 7'h07, 26'(REGION), 4'h0, 32'h0);
    send(3'd4, 3'd1, 7'h08, 26'h11, 4'h0, 32'h0);
    send(3'd4, 3'd2, 7'h09, 26'h10, 4'h0, 32'h0);

    // Three Gets under D backpressure
    rdy_mode = 2;
    fork
      begin
        send(3'd4, 3'd2, 7'h0A, 26'h10, 4'h0, 32'h0);
        send(3'd4, 3'd2, 7'h0B, 26'h14, 4'h0, 32'h0);
        send(3'd4, 3'd2, 7'h0C, 26'h18, 4'h0, 32'h0);
      end
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 0;
      end
    join

    // Reset while a response is pending
    rdy_mode = 2;
    send(3'd4, 3'd2, 7'h0D, 26'h10, 4'h0, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    rdy_mode = 0;
    send(3'd4, 3'd2, 7'h0E, 26'h10, 4'h0, 32'h0);

    // 200 back-to-back Gets
    for (int i = 0; i < 200; i++)
      send(3'd4, 3'd2, 7'($urandom_range(0, 127)), 26'($urandom_range(0, 15) * 4), 4'h0, 32'h0);

    // Randomized mix under random D backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = 26'($urandom_range(0, 63));
      else if (sel < 8) addr = 26'(REGION - 4 + $urandom_range(0, 3));
      else if (sel < 9) addr = 26'(REGION + $urandom_range(0, 255));
      else              addr = 26'h3FFFF00 + 26'($urandom_range(0, 255));
      sel = $urandom_range(0, 15);
      op  = (sel < 4) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 12) ? 3'd4 : 3'(sel - 7);
      if (sel >= 6 && sel < 8) op = 3'(sel - 4);
      size = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      send(op, size, 7'($urandom_range(0, 127)), addr,
           ($urandom_range(0, 1) == 1) ? lanes_of(size, int'(addr)) : 4'($urandom_range(0, 15)),
           $urandom);
    end

    rdy_mode = 0;
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
